// File: rtl/uart_bus_bridge_pkg.sv
// Shared command bytes, frame lengths and state encodings for the
// UART-driven register bus initiator.
package uart_bus_bridge_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] RSP_OK = 8'h4B;

   localparam int unsigned ADDR_BYTES    = 4;
   localparam int unsigned DATA_BYTES    = 4;
   localparam int unsigned RD_RESP_BYTES = 4;
   localparam int unsigned WR_RESP_BYTES = 1;

   typedef enum logic [3:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      BUS_WR,
      BUS_RD,
      RD_CAP,
      RESP,
      DRAIN
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_bus_bridge_phy.sv
// 8N1 serial byte receiver and transmitter with an input synchronizer.
// The transmitter accepts the next byte in the final stop-bit cycle so bytes go out gap-free.
module uart_bus_bridge_phy #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr,
   input  logic [7:0] tx_byte,
   input  logic       tx_start,
   output logic       tx_busy
);
   import uart_bus_bridge_pkg::*;

   localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     rx_state, rx_state_n;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_tick_half, rx_tick_bit;

   logic [9:0]    tx_shift;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_left;
   logic          tx_active;

   assign rx_tick_half = (rx_cnt == HALF_LAST);
   assign rx_tick_bit  = (rx_cnt == BIT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_state_n = RX_START;
         RX_START: if (rx_tick_half) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick_bit && rx_bit == 3'd7) rx_state_n = RX_STOP;
         RX_STOP:  if (rx_tick_bit) rx_state_n = RX_IDLE;
         default:  rx_state_n = RX_IDLE;
      endcase
   end

   // The bit counter restarts on every state change so each sample lands one
   // full bit after the previous one, starting from the mid-start check.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (rx_state == RX_IDLE || rx_state_n != rx_state || rx_tick_bit)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START)
            rx_bit <= '0;
         if (rx_state == RX_DATA && rx_tick_bit) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_state == RX_STOP && rx_tick_bit) begin
            if (rx_sync) begin
               rx_byte  <= rx_shift;
               rx_valid <= 1'b1;
            end else begin
               rx_ferr <= 1'b1;
            end
         end
      end
   end

   assign tx_busy = tx_active && !(tx_left == '0 && tx_cnt == BIT_LAST);
   assign tx      = tx_shift[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_shift  <= '1;
         tx_cnt    <= '0;
         tx_left   <= '0;
         tx_active <= 1'b0;
      end else if (tx_start && !tx_busy) begin
         tx_shift  <= {1'b1, tx_byte, 1'b0};
         tx_cnt    <= '0;
         tx_left   <= 4'd9;
         tx_active <= 1'b1;
      end else if (tx_active) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_left == '0)
               tx_active <= 1'b0;
            else
               tx_left <= tx_left - 1'b1;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames in, single 32-bit register bus transactions out,
// with the response returned on the serial line.
module uart_bus_bridge #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned TIMEOUT_CLKS = 1000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        write_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o,
   input  logic [31:0] rdata_i,
   input  logic        rx,
   output logic        tx,
   output logic        busy_o,
   output logic        err_o
);
   import uart_bus_bridge_pkg::*;

   localparam int unsigned   TW      = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

   state_t        state, state_n;
   logic [7:0]    cmd_q;
   logic [31:0]   addr_sr, data_sr, resp_sr;
   logic [2:0]    byte_cnt, resp_left;
   logic [TW-1:0] to_cnt;
   logic          timeout, addr_done, data_done, err_n, bus_active;
   logic [7:0]    rx_byte, tx_byte;
   logic          rx_valid, rx_ferr, tx_start, tx_busy;

   uart_bus_bridge_phy #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_phy (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rx      (rx),
      .tx      (tx),
      .rx_byte (rx_byte),
      .rx_valid(rx_valid),
      .rx_ferr (rx_ferr),
      .tx_byte (tx_byte),
      .tx_start(tx_start),
      .tx_busy (tx_busy)
   );

   assign addr_done = rx_valid && (byte_cnt == 3'(ADDR_BYTES - 1));
   assign data_done = rx_valid && (byte_cnt == 3'(DATA_BYTES - 1));
   assign timeout   = !rx_valid && (to_cnt == TO_LAST);

   always_comb begin
      state_n  = state;
      err_n    = 1'b0;
      tx_start = 1'b0;
      tx_byte  = RSP_OK;
      case (state)
         IDLE: begin
            if (rx_valid)     state_n = CMD;
            else if (rx_ferr) err_n   = 1'b1;
         end
         CMD: begin
            if (cmd_q == CMD_WR || cmd_q == CMD_RD) begin
               state_n = ADDR;
            end else begin
               err_n   = 1'b1;
               state_n = IDLE;
            end
         end
         ADDR: begin
            if (rx_ferr || timeout) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else if (addr_done) begin
               state_n = (cmd_q == CMD_WR) ? DATA : BUS_RD;
            end
         end
         DATA: begin
            if (rx_ferr || timeout) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else if (data_done) begin
               state_n = BUS_WR;
            end
         end
         BUS_WR: begin
            tx_start = 1'b1;
            tx_byte  = RSP_OK;
            state_n  = RESP;
         end
         BUS_RD: state_n = RD_CAP;
         RD_CAP: begin
            tx_start = 1'b1;
            tx_byte  = rdata_i[31:24];
            state_n  = RESP;
         end
         RESP: begin
            if (resp_left == '0) begin
               state_n = DRAIN;
            end else if (!tx_busy) begin
               tx_start = 1'b1;
               tx_byte  = resp_sr[31:24];
            end
         end
         DRAIN:   if (!tx_busy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         err_o     <= 1'b0;
         cmd_q     <= '0;
         addr_sr   <= '0;
         data_sr   <= '0;
         resp_sr   <= '0;
         byte_cnt  <= '0;
         resp_left <= '0;
         to_cnt    <= '0;
      end else begin
         state <= state_n;
         err_o <= err_n;
         if (state == IDLE && rx_valid)
            cmd_q <= rx_byte;
         if (state_n != state)
            byte_cnt <= '0;
         else if ((state == ADDR || state == DATA) && rx_valid)
            byte_cnt <= byte_cnt + 1'b1;
         if (state == ADDR && rx_valid)
            addr_sr <= {addr_sr[23:0], rx_byte};
         if (state == DATA && rx_valid)
            data_sr <= {data_sr[23:0], rx_byte};
         if ((state == ADDR || state == DATA) && !rx_valid)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;
         // First read byte goes straight from rdata_i; the rest queue here.
         if (state == BUS_WR) begin
            resp_left <= 3'(WR_RESP_BYTES - 1);
         end else if (state == RD_CAP) begin
            resp_sr   <= {rdata_i[23:0], 8'h00};
            resp_left <= 3'(RD_RESP_BYTES - 1);
         end else if (state == RESP && tx_start) begin
            resp_sr   <= {resp_sr[23:0], 8'h00};
            resp_left <= resp_left - 1'b1;
         end
      end
   end

   assign bus_active = (state == BUS_WR) || (state == BUS_RD) || (state == RD_CAP);
   assign write_o    = (state == BUS_WR);
   assign data_be_o  = bus_active ? 4'hF : 4'h0;
   assign addr_o     = bus_active ? addr_sr : '0;
   assign wdata_o    = write_o ? data_sr : '0;
   assign busy_o     = (state != IDLE);

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-driven bus initiator. It receives 8N1 command frames on a serial line and issues single 32-bit read/write transactions on the same word-addressed register bus that peripherals such as the UART block respond to. Responses go back over the serial line. It sits between the board USB-UART pins and the peripheral bus, and gives a host PC debug access to registers without a CPU.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Minimum legal value is 4.
- TIMEOUT_CLKS, 1000000: maximum idle gap between bytes of one frame before the frame is discarded.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, asynchronous and active-high.
- write_o  out  1  one-cycle write strobe.
- data_be_o  out  4  byte enables; constant 4'hF whenever a transaction is presented, 4'h0 otherwise.
- addr_o  out  32  transaction address, held from issue until the response is queued.
- wdata_o  out  32  write data, valid while write_o=1.
- rdata_i  in  32  read data from the responder, registered-read compatible.
- rx  in  1  serial input, asynchronous to clk_i; idle high.
- tx  out  1  serial output; idle high.
- busy_o  out  1  high from the first frame byte until the response's last stop bit ends.
- err_o  out  1  one-cycle pulse on a framing error, an unknown command, or a timeout.

## Operation
Frame format, multi-byte fields big-endian:
- Write: 0x57 'W', then A3 A2 A1 A0, then D3 D2 D1 D0. Response is 0x4B 'K'.
- Read: 0x52 'R', then A3 A2 A1 A0. Response is D3 D2 D1 D0.

Receive path:
- rx passes through a 2-flop synchronizer.
- A falling edge starts a byte. The start bit is re-checked at CLKS_PER_BIT/2 and dropped if high (glitch).
- Data is sampled LSB first at mid-bit.
- Stop bit must be 1. If it is 0: byte discarded, frame aborted, err_o pulses.

Command FSM states: IDLE, CMD, ADDR, DATA, BUS_WR, BUS_RD, RD_CAP, RESP, DRAIN.
- IDLE: the first byte goes to CMD. 0x57/0x52 proceed to ADDR. Any other byte pulses err_o and returns to IDLE.
- ADDR: collects 4 bytes, then goes to DATA ('W') or BUS_RD ('R').
- DATA: collects 4 bytes, then goes to BUS_WR.
- BUS_WR: write_o=1 for exactly one cycle, then RESP with byte 0x4B.
- BUS_RD: addr_o presented, then RD_CAP. RD_CAP captures rdata_i on the next cycle, then RESP with 4 bytes.
- RESP: transmits the queued bytes back to back (10 bit-times each), then DRAIN.
- DRAIN: returns to IDLE once tx is idle.

Boundary conditions:
- Bytes received during BUS_*/RESP/DRAIN are discarded; no queueing.
- Inter-byte timeout: in ADDR or DATA, if TIMEOUT_CLKS cycles pass without a completed byte, go to IDLE and pulse err_o.
- Reset mid-frame or mid-transmit: everything returns to the reset state immediately. tx goes high, possibly truncating a byte.

## Timing
- Reset values: write_o=0, data_be_o=0, addr_o=0, wdata_o=0, tx=1, busy_o=0, err_o=0.
- A byte is complete at the mid-stop-bit sample (9.5 bit-times after the start edge, plus 2 synchronizer cycles).
- Write: write_o asserts 1 cycle after D0 completes. The first 'K' start bit begins 1 cycle after write_o.
- Read: addr_o is valid the cycle after A0 completes, and rdata_i is sampled one cycle later. The first response start bit begins the cycle after capture.
- Transmitted bits last exactly CLKS_PER_BIT cycles. There is no gap between response bytes.
- err_o is never asserted for more than one cycle per event.

## Structure
- Package uart_bus_bridge_pkg holds:
  - command byte constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_OK=8'h4B;
  - the FSM state enum;
  - the frame byte-count constants.
- One sub-module, uart_bus_bridge_phy. It contains the synchronizer, the byte receiver (rx_byte, rx_valid pulse, rx_ferr pulse) and the byte transmitter (tx_byte, tx_start, tx_busy).
- The top level holds the command FSM, the shift registers, the timeout counter and the bus drive.

## Test plan
Bench setting: CLKS_PER_BIT=16, TIMEOUT_CLKS=400.
- Write: send 57 00 00 00 0C DE AD BE EF. Expect one write_o pulse with addr_o=0x0000000C, wdata_o=0xDEADBEEF, data_be_o=F, then tx byte 0x4B.
- Read: send 52 00 00 00 04 with a responder returning 0x12345678 a cycle after the address. Expect tx bytes 12 34 56 78 and no write_o.
- Unknown command: send 0x41. Expect an err_o pulse, no bus activity, and a following valid read still works.
- Framing error: send 52 with a stop bit of 0. Expect err_o, return to IDLE, busy_o=0.
- Timeout: send 57 00 then idle for 500 cycles. Expect err_o and IDLE. A subsequent full write frame completes normally.
- Reset: assert rst_i during the second response byte. Expect tx=1 and all outputs at reset values the same cycle, and a clean frame accepted after release.
